// File: rtl/rect_filler_pkg.sv
// Shared types and constants for the rectangle filler.
// Pixel packing, burst geometry and FSM state encoding.
package rect_filler_pkg;

  localparam logic [7:0] PIX_PAD = 8'h00;
  localparam int BURST_PIXELS = 8;
  localparam int BEAT_PIXELS = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_W0,
    S_W1,
    S_FIN
  } state_t;

  function automatic logic [31:0] pack_pixel(
    input logic [23:0] c
  );
    return {PIX_PAD, c};
  endfunction

endpackage

// File: rtl/rect_filler_beat_masker.sv
// Byte mask for one 4-pixel beat of a burst.
// Ports: bx burst column, beat 0/1, x0/x1 bounds -> mask (1 = skip byte).
module rect_filler_beat_masker
  import rect_filler_pkg::*;
#(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-4:0] bx,
  input  logic               beat,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  output logic [15:0]        mask
);

  logic [COORD_W:0] px;

  always_comb begin
    mask = '0;
    px = '0;
    for (int i = 0; i < BEAT_PIXELS; i++) begin
      // {bx,beat,00} == bx*8 + beat*4
      px = {1'b0, bx, beat, 2'b00}
         + (COORD_W+1)'(i);
      if (px < {1'b0, x0} || px > {1'b0, x1})
        mask[4*i +: 4] = 4'hF;
    end
  end

endmodule

// File: rtl/rect_filler.sv
// Fills an inclusive rectangle of the DDR2 frame buffer with one colour.
// Ports: command (valid/ready, color, x0..y1), FIFO pushes, done pulse.
module rect_filler
  import rect_filler_pkg::*;
#(
  parameter int          H_RES       = 1024,
  parameter int          V_RES       = 768,
  parameter int          LINE_STRIDE = 1024,
  parameter logic [30:0] FB_BASE     = 31'h0001_0000,
  parameter int          COORD_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [23:0]        color,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic               af_full,
  input  logic               wdf_full,
  output logic [127:0]       wdf_din,
  output logic               wdf_wr_en,
  output logic [30:0]        af_addr_din,
  output logic               af_wr_en,
  output logic [15:0]        wdf_mask_din,
  output logic               ready,
  output logic               done
);

  localparam int BXW = COORD_W - 3;
  localparam logic [COORD_W-1:0] X_MAX =
    COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX =
    COORD_W'(V_RES - 1);
  localparam logic [30:0] STRIDE =
    31'(LINE_STRIDE);

  state_t state, state_nx;

  logic [23:0]        color_q;
  logic [COORD_W-1:0] x0_q, x1_q;
  logic [COORD_W-1:0] y_q, y1_q, cnt_q;
  logic [BXW-1:0]     bx_q;
  logic [30:0]        base_q;
  logic               beat;

  logic [COORD_W-1:0] x1_c, y1_c;
  logic               inverted;
  logic               bx_end, row_end;

  assign x1_c = (x1 > X_MAX) ? X_MAX : x1;
  assign y1_c = (y1 > Y_MAX) ? Y_MAX : y1;
  assign inverted = (x0 > x1_c) || (y0 > y1_c);

  assign bx_end  = (bx_q == x1_q[COORD_W-1:3]);
  assign row_end = (y_q == y1_q);

  assign af_addr_din = base_q
    + {{(31-COORD_W){1'b0}}, bx_q, 3'b000};
  assign wdf_din = {4{pack_pixel(color_q)}};

  rect_filler_beat_masker #(
    .COORD_W(COORD_W)
  ) u_masker (
    .bx  (bx_q),
    .beat(beat),
    .x0  (x0_q),
    .x1  (x1_q),
    .mask(wdf_mask_din)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    done      = 1'b0;
    af_wr_en  = 1'b0;
    wdf_wr_en = 1'b0;
    beat      = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (valid)
          state_nx = inverted ? S_FIN : S_INIT;
      end
      S_INIT: begin
        if (cnt_q == '0) state_nx = S_W0;
      end
      S_W0: begin
        if (!af_full && !wdf_full) begin
          af_wr_en  = 1'b1;
          wdf_wr_en = 1'b1;
          state_nx  = S_W1;
        end
      end
      S_W1: begin
        beat = 1'b1;
        if (!wdf_full) begin
          wdf_wr_en = 1'b1;
          state_nx  = (bx_end && row_end)
                    ? S_FIN : S_W0;
        end
      end
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Row base = FB_BASE + y0*LINE_STRIDE is built by
  // one stride add per INIT cycle, y0 cycles in total.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      color_q <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y_q     <= '0;
      y1_q    <= '0;
      cnt_q   <= '0;
      bx_q    <= '0;
      base_q  <= '0;
    end else begin
      if (state == S_IDLE && valid) begin
        color_q <= color;
        x0_q    <= x0;
        x1_q    <= x1_c;
        y_q     <= y0;
        y1_q    <= y1_c;
        cnt_q   <= y0;
        bx_q    <= x0[COORD_W-1:3];
        base_q  <= FB_BASE;
      end
      if (state == S_INIT && cnt_q != '0) begin
        cnt_q  <= cnt_q - COORD_W'(1);
        base_q <= base_q + STRIDE;
      end
      if (state == S_W1 && !wdf_full
          && !(bx_end && row_end)) begin
        if (!bx_end) begin
          bx_q <= bx_q + BXW'(1);
        end else begin
          bx_q   <= x0_q[COORD_W-1:3];
          y_q    <= y_q + COORD_W'(1);
          base_q <= base_q + STRIDE;
        end
      end
    end
  end

endmodule

// File: tb/tb_rect_filler.sv
// Self-checking bench for rect_filler on a reduced 128x64 frame.
// Randomised colours, rectangles and FIFO stalls against a rectangle model.
module tb_rect_filler;

  localparam int H   = 128;
  localparam int V   = 64;
  localparam int STR = 1024;
  localparam int CW  = 10;
  localparam logic [30:0] FB = 31'h0001_0000;
  localparam int LIMIT = 20000;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [23:0]   color;
  logic [CW-1:0] x0, y0, x1, y1;
  logic          af_full, wdf_full;
  logic [127:0]  wdf_din;
  logic          wdf_wr_en;
  logic [30:0]   af_addr_din;
  logic          af_wr_en;
  logic [15:0]   wdf_mask_din;
  logic          ready;
  logic          done;

  rect_filler #(
    .H_RES(H), .V_RES(V), .LINE_STRIDE(STR),
    .FB_BASE(FB), .COORD_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid),
    .color(color), .x0(x0), .y0(y0),
    .x1(x1), .y1(y1),
    .af_full(af_full), .wdf_full(wdf_full),
    .wdf_din(wdf_din), .wdf_wr_en(wdf_wr_en),
    .af_addr_din(af_addr_din),
    .af_wr_en(af_wr_en),
    .wdf_mask_din(wdf_mask_din),
    .ready(ready), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  logic [30:0]  obs_a[$], exp_a[$], sav_a[$];
  logic [127:0] obs_d[$], exp_d[$], sav_d[$];
  logic [15:0]  obs_m[$], exp_m[$], sav_m[$];
  int af_n, wdf_n, done_n, done_cyc;
  int viol_full, viol_ord, viol_hold;
  bit prev_stall;
  logic [30:0]  p_a;
  logic [127:0] p_d;
  logic [15:0]  p_m;

  // Samples 2 time units after each negedge, i.e. the
  // values present at the coming posedge.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (af_addr_din !== p_a
          || wdf_din !== p_d
          || wdf_mask_din !== p_m))
        viol_hold++;
      if (af_wr_en && af_full) viol_full++;
      if (wdf_wr_en && wdf_full) viol_full++;
      if (af_wr_en) begin
        if (wdf_n != 2 * af_n) viol_ord++;
        af_n++;
        obs_a.push_back(af_addr_din);
      end
      if (wdf_wr_en) begin
        if (wdf_n + 1 > 2 * af_n) viol_ord++;
        wdf_n++;
        obs_d.push_back(wdf_din);
        obs_m.push_back(wdf_mask_din);
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      prev_stall = (af_n > 0) && !done
                && !ready && !wdf_wr_en;
      p_a = af_addr_din;
      p_d = wdf_din;
      p_m = wdf_mask_din;
    end
  end

  task automatic clear_obs();
    obs_a.delete(); obs_d.delete(); obs_m.delete();
    af_n = 0; wdf_n = 0; done_n = 0;
    done_cyc = -1;
    viol_full = 0; viol_ord = 0; viol_hold = 0;
    prev_stall = 1'b0;
  endtask

  // Reference: walk the clamped rectangle burst by burst.
  task automatic build_model(
    input logic [23:0] c,
    input int mx0, input int my0,
    input int mx1, input int my1
  );
    logic [31:0] w;
    logic [15:0] m;
    int cx1, cy1, px;
    exp_a.delete(); exp_d.delete(); exp_m.delete();
    w = {8'h00, c};
    cx1 = (mx1 > H - 1) ? H - 1 : mx1;
    cy1 = (my1 > V - 1) ? V - 1 : my1;
    if (mx0 > cx1 || my0 > cy1) return;
    for (int y = my0; y <= cy1; y++)
      for (int b = mx0 / 8; b <= cx1 / 8; b++) begin
        exp_a.push_back(31'(FB + y * STR + b * 8));
        for (int bt = 0; bt < 2; bt++) begin
          m = '0;
          for (int i = 0; i < 4; i++) begin
            px = b * 8 + bt * 4 + i;
            if (px < mx0 || px > cx1)
              m[4*i +: 4] = 4'hF;
          end
          exp_d.push_back({w, w, w, w});
          exp_m.push_back(m);
        end
      end
  endtask

  function automatic bit seq_ok();
    if (obs_a.size() != exp_a.size()) return 0;
    if (obs_d.size() != exp_d.size()) return 0;
    foreach (exp_a[i])
      if (obs_a[i] !== exp_a[i]) return 0;
    foreach (exp_d[i])
      if (obs_d[i] !== exp_d[i]
          || obs_m[i] !== exp_m[i]) return 0;
    return 1;
  endfunction

  task automatic start_cmd(
    input logic [23:0] c,
    input int cx0, input int cy0,
    input int cx1, input int cy1,
    output int acc_c
  );
    clear_obs();
    af_full = 0; wdf_full = 0;
    @(negedge clk);
    for (int k = 0; k < 100 && !ready; k++)
      @(negedge clk);
    color = c;
    x0 = cx0[CW-1:0]; y0 = cy0[CW-1:0];
    x1 = cx1[CW-1:0]; y1 = cy1[CW-1:0];
    valid = 1'b1;
    @(negedge clk);
    acc_c = cyc;
    valid = 1'b0;
  endtask

  task automatic run_cmd(
    input logic [23:0] c,
    input int cx0, input int cy0,
    input int cx1, input int cy1,
    input int pct, input bit poke,
    output int acc_c
  );
    start_cmd(c, cx0, cy0, cx1, cy1, acc_c);
    for (int k = 0; k < LIMIT && done_n == 0; k++) begin
      af_full  = ($urandom_range(99) < pct);
      wdf_full = ($urandom_range(99) < pct);
      if (poke && k == 3) begin
        x0 = 0; y0 = 0; x1 = 7; y1 = 0;
        valid = 1'b1;
      end
      if (poke && k == 5) valid = 1'b0;
      #3;
      if (done_n == 0) @(negedge clk);
    end
    af_full = 0; wdf_full = 0; valid = 1'b0;
    @(negedge clk);
    #3;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 0; color = '0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    af_full = 0; wdf_full = 0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs: ready=%b done=%b want 1/0",
               ready, done);
    end
    tests++;
    if (af_wr_en !== 1'b0 || wdf_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_en: af=%b wdf=%b want 0/0",
               af_wr_en, wdf_wr_en);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_full_screen();
    logic [23:0] c;
    int acc;
    bit nz;
    c = 24'($urandom);
    build_model(c, 0, 0, H - 1, V - 1);
    run_cmd(c, 0, 0, H - 1, V - 1, 0, 0, acc);
    tests++;
    if (!seq_ok()) begin
      fails++;
      $display("FAIL full_seq: got %0d/%0d want %0d/%0d",
               obs_a.size(), obs_d.size(),
               exp_a.size(), exp_d.size());
    end
    tests++;
    if (af_n != H * V / 8 || wdf_n != H * V / 4) begin
      fails++;
      $display("FAIL full_cnt: got %0d/%0d want %0d/%0d",
               af_n, wdf_n, H * V / 8, H * V / 4);
    end
    tests++;
    if (af_n == 0 || obs_a[0] !== FB
        || obs_a[af_n-1] !== FB + 31'(63 * STR + 120))
    begin
      fails++;
      $display("FAIL full_ends: first/last wrong (%0d pushes)",
               af_n);
    end
    nz = 0;
    foreach (obs_m[i]) if (obs_m[i] !== 16'h0) nz = 1;
    tests++;
    if (nz || done_n != 1) begin
      fails++;
      $display("FAIL full_mask_done: nz=%0d done=%0d want 0/1",
               nz, done_n);
    end
  endtask

  task automatic test_single_pixel();
    int acc;
    build_model(24'h123456, 5, 2, 5, 2);
    run_cmd(24'h123456, 5, 2, 5, 2, 0, 0, acc);
    tests++;
    if (!seq_ok() || af_n != 1
        || obs_a[0] !== FB + 31'd2048) begin
      fails++;
      $display("FAIL pix_addr: got %0d pushes want 1 at %h",
               af_n, FB + 31'd2048);
    end
    tests++;
    if (wdf_n != 2 || obs_m[0] !== 16'hFFFF
        || obs_m[1] !== 16'hFF0F) begin
      fails++;
      $display("FAIL pix_mask: got %0d beats want FFFF,FF0F",
               wdf_n);
    end
    tests++;
    if (wdf_n != 2 || obs_d[1][63:32] !== 32'h00123456
        || done_n != 1) begin
      fails++;
      $display("FAIL pix_data: done=%0d want pixel 00123456",
               done_n);
    end
  endtask

  task automatic test_small_rect();
    int acc;
    logic [30:0] ea[4];
    logic [15:0] em[4];
    bit bad;
    ea = '{FB, FB + 31'd8, FB + 31'd1024, FB + 31'd1032};
    em = '{16'hFFFF, 16'h00FF, 16'hFF00, 16'hFFFF};
    build_model(24'hA5C3E1, 6, 0, 9, 1);
    run_cmd(24'hA5C3E1, 6, 0, 9, 1, 0, 0, acc);
    bad = (af_n != 4 || wdf_n != 8);
    if (!bad)
      for (int i = 0; i < 4; i++)
        if (obs_a[i] !== ea[i]) bad = 1;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL rect_addr: got %0d pushes want 4", af_n);
    end
    bad = (wdf_n != 8);
    if (!bad)
      for (int i = 0; i < 8; i++)
        if (obs_m[i] !== em[i % 4]) bad = 1;
    tests++;
    if (bad || !seq_ok() || done_n != 1) begin
      fails++;
      $display("FAIL rect_mask: %0d beats, done=%0d", wdf_n,
               done_n);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    build_model(24'h0F0F0F, 0, 0, 15, 0);
    run_cmd(24'h0F0F0F, 0, 0, 15, 0, 0, 0, acc);
    sav_a = obs_a; sav_d = obs_d; sav_m = obs_m;
    run_cmd(24'h0F0F0F, 0, 0, 15, 0, 50, 1, acc);
    tests++;
    if (obs_a != sav_a || obs_d != sav_d
        || obs_m != sav_m || !seq_ok()) begin
      fails++;
      $display("FAIL bp_seq: got %0d pushes want %0d",
               obs_a.size(), sav_a.size());
    end
    tests++;
    if (viol_full != 0 || viol_ord != 0) begin
      fails++;
      $display("FAIL bp_flow: full=%0d order=%0d want 0/0",
               viol_full, viol_ord);
    end
    tests++;
    if (viol_hold != 0 || done_n != 1) begin
      fails++;
      $display("FAIL bp_hold: hold=%0d done=%0d want 0/1",
               viol_hold, done_n);
    end
  endtask

  task automatic test_inverted_clamp();
    int acc;
    run_cmd(24'h777777, 10, 5, 3, 5, 0, 0, acc);
    tests++;
    if (af_n != 0 || wdf_n != 0 || done_n != 1
        || done_cyc != acc) begin
      fails++;
      $display("FAIL inv: af=%0d wdf=%0d done=%0d dcyc=%0d want 0/0/1/%0d",
               af_n, wdf_n, done_n, done_cyc, acc);
    end
    build_model(24'h445566, 120, 10, 1000, 10);
    run_cmd(24'h445566, 120, 10, 1000, 10, 0, 0, acc);
    tests++;
    if (!seq_ok() || af_n != 1
        || obs_a[0] !== FB + 31'(10 * STR + 120)
        || obs_m[1] !== 16'h0000) begin
      fails++;
      $display("FAIL clamp: got %0d pushes want 1 ending col 127",
               af_n);
    end
  endtask

  task automatic test_random();
    int acc, rx0, ry0, rx1, ry1, pct;
    logic [23:0] c;
    for (int n = 0; n < 8; n++) begin
      c = 24'($urandom);
      rx0 = $urandom_range(0, 140);
      rx1 = $urandom_range(0, 200);
      ry0 = $urandom_range(0, 66);
      ry1 = ry0 + $urandom_range(0, 4);
      pct = $urandom_range(0, 60);
      build_model(c, rx0, ry0, rx1, ry1);
      run_cmd(c, rx0, ry0, rx1, ry1, pct, 0, acc);
      tests++;
      if (!seq_ok() || done_n != 1
          || viol_full != 0 || viol_ord != 0
          || viol_hold != 0) begin
        fails++;
        $display("FAIL rand%0d (%0d,%0d)-(%0d,%0d): got %0d want %0d done=%0d",
                 n, rx0, ry0, rx1, ry1, obs_a.size(),
                 exp_a.size(), done_n);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc, n_before;
    start_cmd(24'h999999, 0, 0, H - 1, V - 1, acc);
    repeat (40) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    tests++;
    if (af_wr_en !== 1'b0 || wdf_wr_en !== 1'b0
        || ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_rst: af=%b wdf=%b ready=%b want 0/0/1",
               af_wr_en, wdf_wr_en, ready);
    end
    n_before = obs_a.size();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #3;
    tests++;
    if (ready !== 1'b1 || obs_a.size() != n_before) begin
      fails++;
      $display("FAIL mid_rel: ready=%b pushes %0d->%0d",
               ready, n_before, obs_a.size());
    end
    build_model(24'h13579B, 20, 3, 35, 4);
    run_cmd(24'h13579B, 20, 3, 35, 4, 20, 1, acc);
    tests++;
    if (!seq_ok() || done_n != 1) begin
      fails++;
      $display("FAIL mid_new: got %0d want %0d done=%0d",
               obs_a.size(), exp_a.size(), done_n);
    end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_full_screen();
    test_single_pixel();
    test_small_rect();
    test_backpressure();
    test_inverted_clamp();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
